// File: rtl/state_poll_if.sv
// Valid/ready/data beat bundle used for the read token, the returned
// state value and the forwarded sample.
interface state_poll_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (
        output valid,
        output data,
        input  ready
    );

    modport consumer (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/state_poll.sv
// Periodic poller for a held-state read port: issues a read token every
// PERIOD idle cycles and forwards the returned value (optionally on change).
module state_poll #(
    parameter int PERIOD   = 16,
    parameter bit ONCHANGE = 1'b1,
    parameter int W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    state_poll_if.producer  rd,
    state_poll_if.consumer  din,
    state_poll_if.producer  dout
);

    localparam int CW = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] CNT_END = CW'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rd_done_q, rd_done_d;
    logic           rsp_done_q, rsp_done_d;
    logic           first_q, first_d;
    logic [W-1:0]   sample_q, sample_d;
    logic [W-1:0]   last_q, last_d;

    logic           rd_vld;
    logic           din_rdy;
    logic           rd_hs;
    logic           din_hs;
    logic           both;
    logic [W-1:0]   cap;
    logic           fwd;

    // Handshake and compare terms; valid/ready depend on registered state only
    always_comb begin
        rd_vld  = (state_q == REQ) && !rd_done_q;
        din_rdy = (state_q == REQ) && !rsp_done_q;
        rd_hs   = rd_vld && rd.ready;
        din_hs  = din_rdy && din.valid;
        both    = (rd_done_q || rd_hs) && (rsp_done_q || din_hs);
        cap     = din_hs ? din.data : sample_q;
        fwd     = !ONCHANGE || first_q || (cap != last_q);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cnt_q == CNT_END) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (both) begin
                    state_d = fwd ? OUT : IDLE;
                end
            end
            OUT: begin
                if (dout.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: idle counter, handshake flags, captured sample
    always_comb begin
        cnt_d      = cnt_q;
        rd_done_d  = rd_done_q;
        rsp_done_d = rsp_done_q;
        first_d    = first_q;
        sample_d   = sample_q;
        last_d     = last_q;
        unique case (state_q)
            IDLE: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REQ: begin
                rd_done_d  = rd_done_q | rd_hs;
                rsp_done_d = rsp_done_q | din_hs;
                if (din_hs) begin
                    sample_d = din.data;
                end
                if (both) begin
                    rd_done_d  = 1'b0;
                    rsp_done_d = 1'b0;
                end
            end
            OUT: begin
                if (dout.ready) begin
                    last_d  = sample_q;
                    first_d = 1'b0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rd_done_q  <= 1'b0;
            rsp_done_q <= 1'b0;
            first_q    <= 1'b1;
            sample_q   <= '0;
            last_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_done_q  <= rd_done_d;
            rsp_done_q <= rsp_done_d;
            first_q    <= first_d;
            sample_q   <= sample_d;
            last_q     <= last_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        rd.valid   = rd_vld;
        rd.data    = '0;
        din.ready  = din_rdy;
        dout.valid = (state_q == OUT);
        dout.data  = sample_q;
    end

endmodule

// File: tb/tb_state_poll.sv
// Randomized scoreboard bench for state_poll: a change-filtered poller with
// a random-latency holder, plus a forward-all PERIOD=1 poller.
`timescale 1ns/1ps
module tb_state_poll;

    localparam int P0 = 4;
    localparam int P1 = 1;
    localparam int W  = 8;
    localparam logic [W-1:0] VALS [5] = '{8'h00, 8'h80, 8'h5A, 8'hA5, 8'h07};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    state_poll_if #(.W(1)) rd0 ();
    state_poll_if #(.W(W)) din0 ();
    state_poll_if #(.W(W)) dout0 ();
    state_poll_if #(.W(1)) rd1 ();
    state_poll_if #(.W(W)) din1 ();
    state_poll_if #(.W(W)) dout1 ();

    state_poll #(.PERIOD(P0), .ONCHANGE(1'b1), .W(W)) u0 (
        .clk(clk), .rst(rst), .rd(rd0), .din(din0), .dout(dout0)
    );

    state_poll #(.PERIOD(P1), .ONCHANGE(1'b0), .W(W)) u1 (
        .clk(clk), .rst(rst), .rd(rd1), .din(din1), .dout(dout1)
    );

    // reference model state
    logic [W-1:0] exp_q [$];
    bit           first_m;
    logic [W-1:0] last_m;
    logic [W-1:0] hold_val = '0;
    bit           hold_fix = 1'b0;
    int           exp_rd = -1;

    task automatic chk_eq(input string nm, input logic [63:0] act,
                          input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // holder + poll timing model for u0
    initial begin : drv
        bit           act;
        bit           rdh;
        bit           dnh;
        bit           outp;
        bit           fwd;
        int           rdd;
        int           dnd;
        int           stall;
        logic [W-1:0] cap;
        act = 0; rdh = 0; dnh = 0; outp = 0; stall = 0;
        rdd = 0; dnd = 0; cap = '0;
        rd0.ready = 0; din0.valid = 0; din0.data = '0; dout0.ready = 0;
        first_m = 1; last_m = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0; outp = 0; exp_rd = -1;
                first_m = 1; last_m = '0;
                exp_q.delete();
                rd0.ready = 0; din0.valid = 0; dout0.ready = 0;
                continue;
            end
            chk_eq("dout_valid", 64'(dout0.valid), 64'(outp));
            if (outp) begin
                chk_eq("stall_no_rd", 64'(rd0.valid), 0);
                rd0.ready = 1'($urandom_range(0, 1));
                din0.valid = 1'($urandom_range(0, 1));
                din0.data = W'($urandom);
                if (stall > 0) begin
                    dout0.ready = 0;
                    stall--;
                end else begin
                    dout0.ready = 1;
                    if (dout0.valid) begin
                        outp = 0;
                        exp_rd = cyc + 1 + P0;
                    end
                end
            end else if (!act) begin
                dout0.ready = 1'($urandom_range(0, 1));
                rd0.ready = 1'($urandom_range(0, 1));
                din0.valid = 1'($urandom_range(0, 1));
                din0.data = W'($urandom);
                if (rd0.valid) begin
                    chk_eq("rd_start", 64'(cyc), 64'(exp_rd));
                    act = 1; rdh = 0; dnh = 0;
                    rdd = int'($urandom_range(0, 3));
                    dnd = int'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) == 0) begin
                        rdd = 0;
                        dnd = 0;
                    end
                end else begin
                    chk_eq("din_rdy_idle", 64'(din0.ready), 0);
                    if (exp_rd >= 0 && cyc >= exp_rd) begin
                        chk_eq("rd_rise", 64'(rd0.valid), 1);
                        exp_rd = -1;
                    end
                    if (!hold_fix && $urandom_range(0, 2) == 0) begin
                        hold_val = VALS[$urandom_range(0, 4)];
                    end
                end
            end
            if (act) begin
                chk_eq("rd_valid", 64'(rd0.valid), 64'(!rdh));
                chk_eq("din_ready", 64'(din0.ready), 64'(!dnh));
                if (rdh) begin
                    rd0.ready = 1'($urandom_range(0, 1));
                end else if (rdd == 0) begin
                    rd0.ready = 1;
                    rdh = rd0.valid;
                end else begin
                    rd0.ready = 0;
                    rdd--;
                end
                if (dnh) begin
                    din0.valid = 1'($urandom_range(0, 1));
                    din0.data = W'($urandom);
                end else if (dnd == 0) begin
                    din0.valid = 1;
                    din0.data = hold_val;
                    if (din0.ready) begin
                        dnh = 1;
                        cap = hold_val;
                    end
                end else begin
                    din0.valid = 0;
                    din0.data = hold_val;
                    dnd--;
                end
                if (rdh && dnh) begin
                    act = 0;
                    fwd = first_m || (cap != last_m);
                    if (fwd) begin
                        exp_q.push_back(cap);
                        last_m = cap;
                        first_m = 0;
                        outp = 1;
                        if ($urandom_range(0, 4) == 0) stall = 10;
                        else stall = int'($urandom_range(0, 2));
                    end else begin
                        exp_rd = cyc + 1 + P0;
                    end
                end
            end
        end
    end

    // output monitor for u0: pops the scoreboard on each dout beat
    initial begin : mon
        logic [W-1:0] pd;
        bit           pv;
        bit           pr;
        pd = '0; pv = 0; pr = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv = 0;
                continue;
            end
            if (dout0.valid && pv && !pr) begin
                chk_eq("dout_stable", 64'(dout0.data), 64'(pd));
            end
            if (dout0.valid && dout0.ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("dout_unexpected", 64'(exp_q.size()), 1);
                end else begin
                    chk_eq("dout_data", 64'(dout0.data), 64'(exp_q.pop_front()));
                end
            end
            pv = dout0.valid;
            pr = dout0.ready;
            pd = dout0.data;
        end
    end

    // forward-all, zero-wait holder on u1: every sample, PERIOD+2 spacing
    initial begin : fa
        logic [W-1:0] q1 [$];
        int           lastb;
        lastb = -1;
        rd1.ready = 1; din1.valid = 1; dout1.ready = 1; din1.data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q1.delete();
                lastb = -1;
                continue;
            end
            din1.data = W'($urandom);
            #1;
            chk_eq("fa_rd_din", 64'(rd1.valid), 64'(din1.ready));
            if (din1.ready) q1.push_back(din1.data);
            if (dout1.valid) begin
                if (q1.size() == 0) begin
                    chk_eq("fa_unexpected", 64'(q1.size()), 1);
                end else begin
                    chk_eq("fa_data", 64'(dout1.data), 64'(q1.pop_front()));
                end
                if (lastb >= 0) chk_eq("fa_gap", 64'(cyc - lastb), 64'(P1 + 2));
                lastb = cyc;
            end
        end
    end

    task automatic reset_outputs_zero(input string tag);
        chk_eq({tag, "_rd_valid"}, 64'(rd0.valid), 0);
        chk_eq({tag, "_rd_data"}, 64'(rd0.data), 0);
        chk_eq({tag, "_din_ready"}, 64'(din0.ready), 0);
        chk_eq({tag, "_dout_valid"}, 64'(dout0.valid), 0);
        chk_eq({tag, "_dout_data"}, 64'(dout0.data), 0);
        chk_eq({tag, "_fa_dout_valid"}, 64'(dout1.valid), 0);
    endtask

    initial begin : ctl
        bit seen;
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        reset_outputs_zero("rst0");
        #2;
        rst = 0;
        exp_rd = cyc + P0;

        repeat (1500) @(negedge clk);

        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = dout0.valid;
        end
        chk_eq("out_wait", 64'(dout0.valid), 1);
        hold_fix = 1;
        hold_val = dout0.data;
        rst = 1;
        #1;
        reset_outputs_zero("rst1");
        repeat (2) @(negedge clk);
        #3;
        rst = 0;
        exp_rd = cyc + P0;

        repeat (100) @(negedge clk);
        hold_fix = 0;
        repeat (500) @(negedge clk);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #2;
        chk_eq("q_drained", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
